unsigned_div_seq: RTL and testbench

- Sequential restoring divider: the inverse direction of the constant-coefficient LUT multiplier (C = A*X).
- Takes a 2N-bit product C and the N-bit constant A, and recovers quotient X and remainder R, one quotient bit per clock.
- Used in the datapath to undo multiplier scaling, and in benches as the independent checker that reconstructs X from C.
- Start/done handshake; one divide in flight at a time.

---
 rtl/unsigned_div_seq.sv | 115 +++++++++++
 tb/tb_unsigned_div_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/unsigned_div_seq.sv
// Sequential restoring divider: recovers Q = floor(C/A) and R = C mod A,
// one quotient bit per clock, behind a start/done handshake.
module unsigned_div_seq #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2*BIT_WIDTH-1:0]   C,
  input  logic [BIT_WIDTH-1:0]     A,
  output logic                     busy,
  output logic                     done,
  output logic [2*BIT_WIDTH-1:0]   Q,
  output logic [BIT_WIDTH-1:0]     R,
  output logic                     ovf,
  output logic                     div_zero
);

  localparam int N  = BIT_WIDTH;
  localparam int W  = 2 * BIT_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   p_reg;    // restored partial remainder is always < A, so N bits suffice
  logic [W-1:0]   sh_reg;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [N-1:0]   a_reg;

  logic [N:0]     p_shift;
  logic           q_bit;
  logic [N-1:0]   p_step;
  logic [W-1:0]   sh_step;
  logic           last_step;

  // One restoring step; the N-bit difference is exact whenever q_bit is set.
  always_comb begin
    p_shift   = {p_reg, sh_reg[W-1]};
    q_bit     = (p_shift >= {1'b0, a_reg});
    p_step    = q_bit ? (p_shift[N-1:0] - a_reg) : p_shift[N-1:0];
    sh_step   = {sh_reg[W-2:0], q_bit};
    last_step = (cnt_reg == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (A == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      p_reg    <= '0;
      sh_reg   <= '0;
      a_reg    <= '0;
      Q        <= '0;
      R        <= '0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= A;
            sh_reg  <= C;
            p_reg   <= '0;
            cnt_reg <= CW'(W);
            if (A == '0) begin
              Q        <= '1;
              R        <= C[N-1:0];
              ovf      <= 1'b1;
              div_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          p_reg   <= p_step;
          sh_reg  <= sh_step;
          cnt_reg <= cnt_reg - CW'(1);
          // Results land on the same edge that enters DONE so they are valid with done.
          if (last_step) begin
            Q        <= sh_step;
            R        <= p_step;
            ovf      <= |sh_step[W-1:N];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Directed bench for unsigned_div_seq: latency, results, overflow, divide by zero,
// ignored starts and mid-operation reset.
module tb_unsigned_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] C_in = '0;
  logic [7:0]  A_in = '0;
  logic        busy, done, ovf, div_zero;
  logic [15:0] Q;
  logic [7:0]  R;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  unsigned_div_seq #(.BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .C(C_in), .A(A_in),
    .busy(busy), .done(done), .Q(Q), .R(R), .ovf(ovf), .div_zero(div_zero)
  );

  // Issues one start from IDLE and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [15:0] c, input logic [7:0] a,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    @(negedge clk);
    C_in = c; A_in = a; start = 1'b1;
    lat = -1; busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin lat = i; break; end
    end
    $display("op C=%0d A=%0d -> Q=%0d R=%0d ovf=%0b dz=%0b lat=%0d", c, a, Q, R, ovf, div_zero, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl busy/done=%b want 00", {busy, done}); else passed++;
    total++; if (Q !== 16'd0) $display("FAIL reset_q got %0d want 0", Q); else passed++;
    total++; if (R !== 8'd0) $display("FAIL reset_r got %0d want 0", R); else passed++;
    total++; if ({ovf, div_zero} !== 2'b00) $display("FAIL reset_flags ovf/dz=%b want 00", {ovf, div_zero}); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(16'd765, 8'd3, lat, bc);
    total++; if (lat != 17) $display("FAIL basic_latency got %0d want 17", lat); else passed++;
    total++; if (bc != 17) $display("FAIL basic_busy_cycles got %0d want 17", bc); else passed++;
    total++; if (Q !== 16'd255) $display("FAIL basic_q got %0d want 255", Q); else passed++;
    total++; if (R !== 8'd0) $display("FAIL basic_r got %0d want 0", R); else passed++;
    total++; if ({ovf, div_zero} !== 2'b00) $display("FAIL basic_flags ovf/dz=%b want 00", {ovf, div_zero}); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL basic_after_done busy/done=%b want 00", {busy, done}); else passed++;
    total++; if (Q !== 16'd255) $display("FAIL basic_hold_q got %0d want 255", Q); else passed++;
  endtask

  task automatic test_small();
    int lat, bc;
    run_op(16'd10, 8'd3, lat, bc);
    total++; if ({Q, R, ovf} !== {16'd3, 8'd1, 1'b0}) $display("FAIL small_10_3 got Q=%0d R=%0d ovf=%0b want Q=3 R=1 ovf=0", Q, R, ovf); else passed++;
    run_op(16'd0, 8'd7, lat, bc);
    total++; if ({Q, R, ovf} !== {16'd0, 8'd0, 1'b0}) $display("FAIL small_0_7 got Q=%0d R=%0d ovf=%0b want Q=0 R=0 ovf=0", Q, R, ovf); else passed++;
    run_op(16'd1000, 8'd255, lat, bc);
    total++; if ({Q, R} !== {16'd3, 8'd235}) $display("FAIL small_1000_255 got Q=%0d R=%0d want Q=3 R=235", Q, R); else passed++;
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [15:0] x;
    for (int i = 0; i < 256; i++) begin
      x = 16'(i);
      run_op(16'(3 * i), 8'd3, lat, bc);
      total++;
      if (Q !== x || R !== 8'd0 || ovf !== 1'b0 || lat != 17)
        $display("FAIL sweep_x%0d got Q=%0d R=%0d ovf=%0b lat=%0d want Q=%0d R=0 ovf=0 lat=17", i, Q, R, ovf, lat, i);
      else passed++;
    end
  endtask

  task automatic test_ovf();
    int lat, bc;
    run_op(16'd65535, 8'd1, lat, bc);
    total++; if (Q !== 16'd65535) $display("FAIL ovf_q got %0d want 65535", Q); else passed++;
    total++; if ({R, ovf, div_zero} !== {8'd0, 1'b1, 1'b0}) $display("FAIL ovf_flags got R=%0d ovf=%0b dz=%0b want R=0 ovf=1 dz=0", R, ovf, div_zero); else passed++;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(16'h1234, 8'd0, lat, bc);
    total++; if (lat != 1) $display("FAIL dz_latency got %0d want 1", lat); else passed++;
    total++; if (bc != 1) $display("FAIL dz_busy_cycles got %0d want 1", bc); else passed++;
    total++; if ({Q, R} !== {16'hFFFF, 8'h34}) $display("FAIL dz_result got Q=%h R=%h want Q=ffff R=34", Q, R); else passed++;
    total++; if ({ovf, div_zero} !== 2'b11) $display("FAIL dz_flags ovf/dz=%b want 11", {ovf, div_zero}); else passed++;
  endtask

  task automatic test_ignored_start();
    int lat;
    @(negedge clk); @(negedge clk);
    C_in = 16'd1000; A_in = 8'd7; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = (i == 5);
      if (i == 5) begin C_in = 16'd50; A_in = 8'd5; end
      if (done) begin lat = i; break; end
    end
    $display("op C=1000 A=7 (restart at t+5) -> Q=%0d R=%0d lat=%0d", Q, R, lat);
    total++; if (lat != 17) $display("FAIL busy_start_latency got %0d want 17", lat); else passed++;
    total++; if ({Q, R} !== {16'd142, 8'd6}) $display("FAIL busy_start_result got Q=%0d R=%0d want Q=142 R=6", Q, R); else passed++;
    // Start held through the done cycle must not launch a new divide.
    C_in = 16'd20; A_in = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL done_start_busy got %0b want 0", busy); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL done_start_idle busy/done=%b want 00", {busy, done}); else passed++;
    total++; if (Q !== 16'd142) $display("FAIL done_start_hold_q got %0d want 142", Q); else passed++;
  endtask

  task automatic test_abort();
    int lat, bc, done_seen;
    @(negedge clk); @(negedge clk);
    C_in = 16'd100; A_in = 8'd9; start = 1'b1;
    done_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) done_seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({busy, done, ovf, div_zero} !== 4'b0000) $display("FAIL abort_ctrl busy/done/ovf/dz=%b want 0000", {busy, done, ovf, div_zero}); else passed++;
    total++; if ({Q, R} !== 24'd0) $display("FAIL abort_result got Q=%0d R=%0d want 0 0", Q, R); else passed++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    $display("op C=100 A=9 aborted at t+8 -> done pulses=%0d", done_seen);
    total++; if (done_seen != 0) $display("FAIL abort_no_done got %0d pulses want 0", done_seen); else passed++;
    run_op(16'd100, 8'd9, lat, bc);
    total++; if ({Q, R, lat} !== {16'd11, 8'd1, 32'sd17}) $display("FAIL abort_fresh got Q=%0d R=%0d lat=%0d want Q=11 R=1 lat=17", Q, R, lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_sweep();
    test_ovf();
    test_div_zero();
    test_ignored_start();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
